song_sequencer: RTL
===================

// Module: song_sequencer
// PURPOSE
// - Upstream feeder of the points state machine: steps through a song note ROM at a fixed tempo
//   and presents the current expected 4-lane note as song_data, which scoring compares with buttons.
// - Owns tempo, the ROM address/prefetch, pause and end-of-song; scoring consumes song_data/step_tick.
// PARAMETERS
// - TICKS_PER_STEP  25_000_000  clk cycles per note step; legal range >= 3 (needed for prefetch).
// - SONG_LEN        64          notes in the song, indices 0..SONG_LEN-1; legal range >= 1.
// - ADDR_W          6           ROM address width; 2**ADDR_W >= SONG_LEN.
// PORTS
// - clk        in   1       single system clock, all logic on posedge.
// - rst        in   1       synchronous, active-high reset.
// - start      in   1       level-sampled; starts the song from note 0 when in IDLE or DONE.
// - pause      in   1       level; while high in PLAY, tempo is frozen and song_data is held.
// - rom_addr   out  ADDR_W  note ROM address (registered).
// - rom_data   in   4       ROM note; valid 1 cycle after rom_addr changes (synchronous ROM).
// - song_data  out  4       current expected note, one bit per lane; 0 = rest.
// - step_tick  out  1       1-cycle pulse, asserted in the same cycle song_data takes a new note.
// - playing    out  1       high in PLAY while pause is low.
// - song_done  out  1       high in DONE.
// BEHAVIOUR
// - All outputs registered. Reset values: state=IDLE, rom_addr=0, song_data=0, step_tick=0,
//   playing=0, song_done=0, tempo counter=0, prefetch register=0. Reset mid-song aborts immediately.
// - States: IDLE -start-> FETCH -> PRIME -> PLAY -last step expires-> DONE -start-> FETCH.
//   FETCH: drive rom_addr=0. PRIME: latch rom_data into prefetch register.
//   PLAY entry cycle: song_data<=prefetch, step_tick=1, counter=0, rom_addr<=1.
// - Latency: start high in cycle 0 -> FETCH in cycle 1 -> PRIME in cycle 2 -> first step_tick and
//   first note in cycle 3.
// - In PLAY, counter increments each unpaused cycle; at counter==TICKS_PER_STEP-1 the next cycle is
//   a step: step_tick=1, song_data<=prefetch, counter<=0, rom_addr<=rom_addr+1.
//   Prefetch register captures rom_data 2 cycles after each rom_addr update, always before the next step.
// - End: the step that would present index SONG_LEN instead enters DONE. In DONE: song_data=0,
//   song_done=1, no step_tick, rom_addr=0. Note SONG_LEN-1 is held the full TICKS_PER_STEP cycles.
// - SONG_LEN==1: the single note is held one step period, then DONE.
// - Pause: only in PLAY. Counter and song_data frozen, step_tick suppressed, playing=0. On release,
//   the remaining count resumes (no step lost, no extra step). Ignored in IDLE/FETCH/PRIME/DONE.
// - start in FETCH/PRIME/PLAY: ignored. start held high in DONE restarts at once (no edge detect).
// - pause and step boundary in the same cycle: pause wins; the step fires on the first unpaused cycle.
// - rst has priority over start and pause.
// - Counter width: $clog2(TICKS_PER_STEP); counter never exceeds TICKS_PER_STEP-1.
// CONFIGURATION
// - SONG_LOOP_EN defined: no DONE from PLAY. After note SONG_LEN-1, rom_addr wraps to 0 and note 0
//   is prefetched. The step stream continues unbroken at the same period; song_done stays 0.
// - SONG_LOOP_EN undefined: end-of-song behaviour as above (DONE).
// TESTING (TICKS_PER_STEP=4, SONG_LEN=3, ROM = {4'b0001, 4'b0010, 4'b0100})
// - rst then start=1 in cycle 0 -> step_tick in cycles 3/7/11 with song_data 1/2/4;
//   cycle 15: song_done=1, song_data=0, no tick.
// - pause high for 5 cycles starting at cycle 5 -> song_data stays 1; second tick moves from
//   cycle 7 to 12, third to 16.
// - rst asserted in cycle 8 mid-song -> cycle 9 all outputs at reset values; start -> replay from note 0.
// - start held high continuously -> immediate restart from DONE; start pulses during PLAY change nothing.
// - SONG_LOOP_EN build -> ticks every 4 cycles forever, song_data sequence 1,2,4,1,2,4; song_done=0.
// - SONG_LEN=1, ROM[0]=4'b1000 -> tick in cycle 3 with song_data 8; DONE in cycle 7.

Source files
------------

// File: rtl/song_sequencer.sv
// Note-ROM sequencer: steps a synchronous note ROM at a fixed tempo and presents the current 4-lane note.
// Build option: define SONG_LOOP_EN to wrap back to note 0 at the end of the song instead of entering DONE.
module song_sequencer #(
    parameter int TICKS_PER_STEP = 25_000_000,
    parameter int SONG_LEN       = 64,
    parameter int ADDR_W         = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        song_data,
    output logic              step_tick,
    output logic              playing,
    output logic              song_done
);

    localparam int                CNT_W    = $clog2(TICKS_PER_STEP);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

`ifdef SONG_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PRIME,
        S_PLAY,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] r_cur_idx;
    logic [3:0]        r_song_data;
    logic [3:0]        r_prefetch;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_pf_pend;
    logic              r_step_tick;
    logic              r_playing;
    logic              r_song_done;

    logic              w_boundary;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_boundary = (r_cnt == CNT_LAST);
    assign w_last     = (r_cur_idx == LAST_IDX);
    // The address after the last note wraps to 0 so note 0 is already prefetched when looping.
    assign w_addr_inc = (r_rom_addr == LAST_IDX) ? '0 : r_rom_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rom_addr  <= '0;
            r_cur_idx   <= '0;
            r_song_data <= '0;
            r_prefetch  <= '0;
            r_cnt       <= '0;
            r_pf_pend   <= '0;
            r_step_tick <= 1'b0;
            r_playing   <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_step_tick <= 1'b0;
            // ROM data is valid one cycle after an address update; capture it on the cycle after that.
            r_pf_pend   <= {r_pf_pend[0], 1'b0};
            if (r_pf_pend[1]) begin
                r_prefetch <= rom_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_rom_addr <= '0;
                    end
                end
                S_FETCH: begin
                    r_state <= S_PRIME;
                end
                S_PRIME: begin
                    // Note 0 arrives from the ROM this cycle and is presented directly.
                    r_state     <= S_PLAY;
                    r_prefetch  <= rom_data;
                    r_song_data <= rom_data;
                    r_step_tick <= 1'b1;
                    r_cnt       <= '0;
                    r_cur_idx   <= '0;
                    r_rom_addr  <= w_addr_inc;
                    r_pf_pend   <= 2'b01;
                    r_playing   <= ~pause;
                end
                S_PLAY: begin
                    r_playing <= ~pause;
                    if (!pause) begin
                        if (w_boundary) begin
                            r_cnt <= '0;
                            if (w_last && !LOOP_EN) begin
                                r_state     <= S_DONE;
                                r_song_data <= '0;
                                r_song_done <= 1'b1;
                                r_rom_addr  <= '0;
                                r_playing   <= 1'b0;
                            end else begin
                                r_step_tick <= 1'b1;
                                r_song_data <= r_prefetch;
                                r_rom_addr  <= w_addr_inc;
                                r_pf_pend   <= 2'b01;
                                r_cur_idx   <= w_last ? '0 : r_cur_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_song_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = r_rom_addr;
    assign song_data = r_song_data;
    assign step_tick = r_step_tick;
    assign playing   = r_playing;
    assign song_done = r_song_done;

endmodule
